// File: rtl/book_pkg.sv
// Shared types for the ITCH price-level book: update opcodes, sides and the level record.
// Price and share widths are fixed here because the level record crosses every port.
package book_pkg;

    localparam int unsigned PRICE_W = 32;
    localparam int unsigned QTY_W   = 32;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_DEL  = 2'd1,
        OP_EXEC = 2'd2
    } bookOpType;

    typedef enum logic {
        BUY  = 1'b0,
        SELL = 1'b1
    } sideType;

    typedef struct packed {
        logic               valid;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   shares;
    } bookLevelType;

    // A resting level is worse than a new price when the new price would sort ahead of it.
    function automatic logic isWorse(input logic [PRICE_W-1:0] levelPrice,
                                     input logic [PRICE_W-1:0] newPrice,
                                     input logic               isSell);
        return isSell ? (levelPrice > newPrice) : (levelPrice < newPrice);
    endfunction

endpackage

// File: rtl/itch_book_levels_if.sv
// Book update handshake from the ITCH parser / ref-num lookup stage.
// Transfer happens when updValidIn and updReadyOut are both high at a clock edge.
interface itch_book_levels_if;

    logic                         updValidIn;
    logic                         updReadyOut;
    book_pkg::bookOpType          updOpIn;
    book_pkg::sideType            updSideIn;
    logic [book_pkg::PRICE_W-1:0] updPriceIn;
    logic [book_pkg::QTY_W-1:0]   updSharesIn;

    modport master (
        output updValidIn, updOpIn, updSideIn, updPriceIn, updSharesIn,
        input  updReadyOut
    );

    modport slave (
        input  updValidIn, updOpIn, updSideIn, updPriceIn, updSharesIn,
        output updReadyOut
    );

endinterface

// File: rtl/book_side.sv
// One side of the price-level book: level array, price search and shift-insert/remove.
// IS_SELL selects ordering (buy: highest price at index 0, sell: lowest at index 0).
module book_side
    import book_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter bit          IS_SELL = 1'b0
) (
    input  logic               clkIn,
    input  logic               rstBIn,
    input  logic               searchEn,
    input  logic               applyEn,
    input  bookOpType          opIn,
    input  logic [PRICE_W-1:0] priceIn,
    input  logic [QTY_W-1:0]   sharesIn,
    output bookLevelType       levelsOut [DEPTH],
    output logic               changedOut,
    output logic               matchHitOut,
    output logic               insHitOut
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bookLevelType     levelsQ [DEPTH];
    bookLevelType     levelsD [DEPTH];
    bookLevelType     matchLev;
    logic [IDX_W-1:0] matchIdxD, matchIdxQ, insIdxD, insIdxQ;
    logic             matchHitD, matchHitQ, insHitD, insHitQ;
    logic [QTY_W:0]   addSum;

    // Scan from the back so the lowest qualifying index wins.
    always_comb begin
        matchHitD = 1'b0;
        matchIdxD = '0;
        insHitD   = 1'b0;
        insIdxD   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (levelsQ[i].valid && (levelsQ[i].price == priceIn)) begin
                matchHitD = 1'b1;
                matchIdxD = IDX_W'(i);
            end
            if (!levelsQ[i].valid || isWorse(levelsQ[i].price, priceIn, IS_SELL)) begin
                insHitD = 1'b1;
                insIdxD = IDX_W'(i);
            end
        end
    end

    always_comb begin
        matchLev = levelsQ[matchIdxQ];
        addSum   = {1'b0, matchLev.shares} + {1'b0, sharesIn};
        levelsD  = levelsQ;
        if (applyEn) begin
            if (opIn == OP_ADD) begin
                if (matchHitQ) begin
                    levelsD[matchIdxQ].shares = addSum[QTY_W] ? '1 : addSum[QTY_W-1:0];
                end else if (insHitQ) begin
                    // Shifting down past the last slot discards the old worst level.
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        if (i > int'(insIdxQ)) levelsD[i] = levelsQ[i-1];
                    end
                    levelsD[insIdxQ].valid  = 1'b1;
                    levelsD[insIdxQ].price  = priceIn;
                    levelsD[insIdxQ].shares = sharesIn;
                end
            end else if (matchHitQ) begin
                if (sharesIn >= matchLev.shares) begin
                    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                        if (i >= int'(matchIdxQ)) levelsD[i] = levelsQ[i+1];
                    end
                    levelsD[DEPTH-1] = '0;
                end else begin
                    levelsD[matchIdxQ].shares = matchLev.shares - sharesIn;
                end
            end
        end
    end

    always_comb begin
        changedOut = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (levelsD[i] != levelsQ[i]) changedOut = 1'b1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstBIn) begin
            for (int i = 0; i < int'(DEPTH); i++) levelsQ[i] <= '0;
            matchHitQ <= 1'b0;
            matchIdxQ <= '0;
            insHitQ   <= 1'b0;
            insIdxQ   <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) levelsQ[i] <= levelsD[i];
            if (searchEn) begin
                matchHitQ <= matchHitD;
                matchIdxQ <= matchIdxD;
                insHitQ   <= insHitD;
                insIdxQ   <= insIdxD;
            end
        end
    end

    assign levelsOut   = levelsQ;
    assign matchHitOut = matchHitQ;
    assign insHitOut   = insHitQ;

endmodule

// File: rtl/itch_book_levels.sv
// Two-sided aggregated price-level book: IDLE -> SEARCH -> APPLY per update, one per 3 cycles.
// Define ITCH_BOOK_STATS_EN to build the add/off-book/miss counters; otherwise they read 0.
module itch_book_levels
    import book_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clkIn,
    input  logic                rstBIn,
    itch_book_levels_if.slave   upd,
    output bookLevelType        buyLevelsOut  [DEPTH],
    output bookLevelType        sellLevelsOut [DEPTH],
    output bookLevelType        topBuyOut,
    output bookLevelType        topSellOut,
    output logic                bookUpdOut,
    output logic [CNT_W-1:0]    addCntOut,
    output logic [CNT_W-1:0]    offBookCntOut,
    output logic [CNT_W-1:0]    missCntOut
);

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StApply
    } stateType;

    stateType           stateQ, stateD;
    bookOpType          opQ;
    sideType            sideQ;
    logic [PRICE_W-1:0] priceQ;
    logic [QTY_W-1:0]   sharesQ;
    logic               bookUpdQ;
    logic               xfer;
    logic               buyChanged, sellChanged, selChanged;
    logic               buyMatchHit, sellMatchHit, selMatchHit;
    logic               buyInsHit, sellInsHit, selInsHit;

    assign upd.updReadyOut = rstBIn && (stateQ == StIdle);
    assign xfer            = upd.updValidIn && upd.updReadyOut;

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:   if (xfer) stateD = StSearch;
            StSearch: stateD = StApply;
            StApply:  stateD = StIdle;
            default:  stateD = StIdle;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!rstBIn) begin
            stateQ   <= StIdle;
            opQ      <= OP_ADD;
            sideQ    <= BUY;
            priceQ   <= '0;
            sharesQ  <= '0;
            bookUpdQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            bookUpdQ <= (stateQ == StApply) && selChanged;
            if (xfer) begin
                opQ     <= upd.updOpIn;
                sideQ   <= upd.updSideIn;
                priceQ  <= upd.updPriceIn;
                sharesQ <= upd.updSharesIn;
            end
        end
    end

    book_side #(
        .DEPTH   (DEPTH),
        .IS_SELL (1'b0)
    ) uBuy (
        .clkIn       (clkIn),
        .rstBIn      (rstBIn),
        .searchEn    ((stateQ == StSearch) && (sideQ == BUY)),
        .applyEn     ((stateQ == StApply) && (sideQ == BUY)),
        .opIn        (opQ),
        .priceIn     (priceQ),
        .sharesIn    (sharesQ),
        .levelsOut   (buyLevelsOut),
        .changedOut  (buyChanged),
        .matchHitOut (buyMatchHit),
        .insHitOut   (buyInsHit)
    );

    book_side #(
        .DEPTH   (DEPTH),
        .IS_SELL (1'b1)
    ) uSell (
        .clkIn       (clkIn),
        .rstBIn      (rstBIn),
        .searchEn    ((stateQ == StSearch) && (sideQ == SELL)),
        .applyEn     ((stateQ == StApply) && (sideQ == SELL)),
        .opIn        (opQ),
        .priceIn     (priceQ),
        .sharesIn    (sharesQ),
        .levelsOut   (sellLevelsOut),
        .changedOut  (sellChanged),
        .matchHitOut (sellMatchHit),
        .insHitOut   (sellInsHit)
    );

    assign selChanged  = (sideQ == SELL) ? sellChanged  : buyChanged;
    assign selMatchHit = (sideQ == SELL) ? sellMatchHit : buyMatchHit;
    assign selInsHit   = (sideQ == SELL) ? sellInsHit   : buyInsHit;

    assign topBuyOut  = buyLevelsOut[0];
    assign topSellOut = sellLevelsOut[0];
    assign bookUpdOut = bookUpdQ;

`ifdef ITCH_BOOK_STATS_EN
    logic [CNT_W-1:0] addCntQ, offBookCntQ, missCntQ;

    always_ff @(posedge clkIn) begin
        if (!rstBIn) begin
            addCntQ     <= '0;
            offBookCntQ <= '0;
            missCntQ    <= '0;
        end else begin
            if (xfer && (upd.updOpIn == OP_ADD)) addCntQ <= addCntQ + 1'b1;
            if (stateQ == StApply) begin
                if ((opQ == OP_ADD) && !selMatchHit && !selInsHit) begin
                    offBookCntQ <= offBookCntQ + 1'b1;
                end
                if ((opQ != OP_ADD) && !selMatchHit) missCntQ <= missCntQ + 1'b1;
            end
        end
    end

    assign addCntOut     = addCntQ;
    assign offBookCntOut = offBookCntQ;
    assign missCntOut    = missCntQ;
`else
    logic unusedStats;
    assign unusedStats   = ^{selMatchHit, selInsHit};
    assign addCntOut     = '0;
    assign offBookCntOut = '0;
    assign missCntOut    = '0;
`endif

endmodule

// File: tb/tb_itch_book_levels.sv
// Randomised bench for itch_book_levels against a sorted-list reference model of both sides.
module tb_itch_book_levels;
    import book_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;
`ifdef ITCH_BOOK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clkIn = 1'b0;
    logic             rstBIn = 1'b0;
    bookLevelType     buyLevels  [DEPTH];
    bookLevelType     sellLevels [DEPTH];
    bookLevelType     topBuy, topSell;
    logic             bookUpd;
    logic [CNT_W-1:0] addCnt, offBookCnt, missCnt;

    itch_book_levels_if bif ();

    itch_book_levels #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clkIn         (clkIn),
        .rstBIn        (rstBIn),
        .upd           (bif),
        .buyLevelsOut  (buyLevels),
        .sellLevelsOut (sellLevels),
        .topBuyOut     (topBuy),
        .topSellOut    (topSell),
        .bookUpdOut    (bookUpd),
        .addCntOut     (addCnt),
        .offBookCntOut (offBookCnt),
        .missCntOut    (missCnt)
    );

    always #5 clkIn = ~clkIn;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] price;
        logic [31:0] shares;
    } lvlT;

    lvlT              buyQ[$];
    lvlT              sellQ[$];
    logic [CNT_W-1:0] mAdd, mOff, mMiss;
    logic             expUpd;

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] expLvl(input int side, input int i);
        lvlT q[$];
        if (side == 1) q = sellQ;
        else q = buyQ;
        if (i < q.size()) return {63'd0, 1'b1, q[i].price, q[i].shares};
        return '0;
    endfunction

    // Book as an ordered list: best first, equal prices merge, at most DEPTH entries kept.
    task automatic mdlApply(input int op, input int side, input logic [31:0] price,
                            input logic [31:0] shares);
        lvlT         q[$];
        lvlT         item;
        int          idx = -1;
        int          pos = 0;
        logic [32:0] sum;
        if (side == 1) q = sellQ;
        else q = buyQ;
        expUpd = 1'b0;
        foreach (q[i]) if (q[i].price == price) idx = i;
        if (op == 0) begin
            mAdd++;
            if (idx >= 0) begin
                sum = {1'b0, q[idx].shares} + {1'b0, shares};
                if (sum > 33'h0FFFFFFFF) sum = 33'h0FFFFFFFF;
                expUpd = (sum[31:0] != q[idx].shares);
                q[idx].shares = sum[31:0];
            end else begin
                foreach (q[i]) begin
                    if ((side == 1) ? (q[i].price < price) : (q[i].price > price)) pos++;
                end
                if (pos >= int'(DEPTH)) mOff++;
                else begin
                    item.price  = price;
                    item.shares = shares;
                    q.insert(pos, item);
                    if (q.size() > int'(DEPTH)) q.pop_back();
                    expUpd = 1'b1;
                end
            end
        end else begin
            if (idx < 0) mMiss++;
            else if (shares >= q[idx].shares) begin
                q.delete(idx);
                expUpd = 1'b1;
            end else begin
                q[idx].shares = q[idx].shares - shares;
                expUpd = (shares != 0);
            end
        end
        if (side == 1) sellQ = q;
        else buyQ = q;
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            checkEq($sformatf("%s buy[%0d]", tag, i), 128'(buyLevels[i]), expLvl(0, i));
            checkEq($sformatf("%s sell[%0d]", tag, i), 128'(sellLevels[i]), expLvl(1, i));
        end
        checkEq({tag, " topBuy"}, 128'(topBuy), expLvl(0, 0));
        checkEq({tag, " topSell"}, 128'(topSell), expLvl(1, 0));
        checkEq({tag, " bookUpd"}, 128'(bookUpd), 128'(expUpd));
        checkEq({tag, " addCnt"}, 128'(addCnt), STATS ? 128'(mAdd) : 128'd0);
        checkEq({tag, " offBookCnt"}, 128'(offBookCnt), STATS ? 128'(mOff) : 128'd0);
        checkEq({tag, " missCnt"}, 128'(missCnt), STATS ? 128'(mMiss) : 128'd0);
    endtask

    task automatic drive(input int op, input int side, input logic [31:0] price,
                         input logic [31:0] shares);
        bif.updOpIn     = bookOpType'(op);
        bif.updSideIn   = sideType'(side);
        bif.updPriceIn  = price;
        bif.updSharesIn = shares;
    endtask

    // Called at a negedge; returns at the negedge after the result became visible.
    task automatic doUpd(input string tag, input int op, input int side,
                         input logic [31:0] price, input logic [31:0] shares);
        int guard = 0;
        while (!bif.updReadyOut && guard < 20) begin
            @(negedge clkIn);
            guard++;
        end
        if (!bif.updReadyOut) begin
            checkEq({tag, " readyWait"}, 128'(bif.updReadyOut), 128'd1);
            return;
        end
        drive(op, side, price, shares);
        bif.updValidIn = 1'b1;
        @(posedge clkIn);
        #1 bif.updValidIn = 1'b0;
        @(negedge clkIn);
        @(negedge clkIn);
        checkEq({tag, " earlyUpd"}, 128'(bookUpd), 128'd0);
        checkEq({tag, " earlyTopBuy"}, 128'(topBuy), expLvl(0, 0));
        checkEq({tag, " earlyTopSell"}, 128'(topSell), expLvl(1, 0));
        mdlApply(op, side, price, shares);
        @(negedge clkIn);
        checkAll(tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers;
        bif.updValidIn = 1'b0;
        drive(0, 0, 32'd0, 32'd0);
        mAdd = '0; mOff = '0; mMiss = '0; expUpd = 1'b0;
        rstBIn = 1'b0;
        repeat (3) @(negedge clkIn);
        checkEq("rst ready", 128'(bif.updReadyOut), 128'd0);
        checkAll("rst");
        rstBIn = 1'b1;
        @(negedge clkIn);

        doUpd("t1", 0, 0, 32'h0022FEFC, 32'h45);
        checkEq("t1 topBuyConst", 128'(topBuy), 128'({1'b1, 32'h0022FEFC, 32'h45}));
        checkEq("t1 pulse", 128'(bookUpd), 128'd1);
        @(negedge clkIn);
        checkEq("t1 pulseOneCycle", 128'(bookUpd), 128'd0);

        doUpd("t2a", 0, 0, 32'h0022FEFC, 32'h555);
        checkEq("t2 merged", 128'(buyLevels[0].shares), 128'h59A);
        doUpd("t2b", 0, 0, 32'h00224000, 32'h554);
        doUpd("t2c", 0, 0, 32'h00224000, 32'h553);
        checkEq("t2 lvl1", 128'(buyLevels[1].shares), 128'hAA7);

        doUpd("t3a", 0, 0, 32'h00222000, 32'h10);
        doUpd("t3b", 0, 0, 32'h00221000, 32'h20);
        doUpd("t3off", 0, 0, 32'h00220000, 32'h30);
        checkEq("t3 offNoPulse", 128'(bookUpd), 128'd0);
        doUpd("t3ins", 0, 0, 32'h00223000, 32'h40);
        checkEq("t3 insIdx2", 128'(buyLevels[2].price), 128'h00223000);
        checkEq("t3 dropped", 128'(buyLevels[3].price), 128'h00222000);

        doUpd("t4del", 1, 0, 32'h0022FEFC, 32'h59A);
        checkEq("t4 slot3", 128'(buyLevels[3].valid), 128'd0);
        doUpd("t4miss", 1, 0, 32'h00000001, 32'h10);

        doUpd("t5a", 0, 1, 32'h00230000, 32'h100);
        doUpd("t5exec", 2, 1, 32'h00230000, 32'hABCD7684);
        checkEq("t5 removed", 128'(topSell.valid), 128'd0);
        doUpd("t5b", 0, 1, 32'h00231000, 32'hFFFFFFF0);
        doUpd("t5sat", 0, 1, 32'h00231000, 32'h100);
        checkEq("t5 saturate", 128'(sellLevels[0].shares), 128'hFFFFFFFF);

        // Valid held high: only every third cycle may transfer.
        drive(0, 0, 32'h00224000, 32'd0);
        bif.updValidIn = 1'b1;
        xfers = 0;
        for (int n = 0; n < 12; n++) begin
            if (bif.updReadyOut) begin
                xfers++;
                mdlApply(0, 0, 32'h00224000, 32'd0);
            end
            if (n == 11) bif.updValidIn = 1'b0;
            @(negedge clkIn);
        end
        checkEq("t6 xfers", 128'(xfers), 128'd4);
        checkAll("t6hold");

        // Reset while the update sits in APPLY.
        drive(0, 0, 32'h00225000, 32'd5);
        bif.updValidIn = 1'b1;
        @(posedge clkIn);
        #1 bif.updValidIn = 1'b0;
        @(negedge clkIn);
        @(negedge clkIn);
        rstBIn = 1'b0;
        @(negedge clkIn);
        buyQ.delete();
        sellQ.delete();
        mAdd = '0; mOff = '0; mMiss = '0; expUpd = 1'b0;
        checkEq("t6 rstReady", 128'(bif.updReadyOut), 128'd0);
        checkAll("t6rst");
        rstBIn = 1'b1;
        @(negedge clkIn);
        checkEq("t6 readyBack", 128'(bif.updReadyOut), 128'd1);

        for (int k = 0; k < 300; k++) begin
            int          op, side, r;
            logic [31:0] price, shares;
            r     = $urandom % 4;
            op    = (r < 2) ? 0 : r - 1;
            side  = $urandom % 2;
            price = 32'h00220000 + 32'($urandom_range(0, 9)) * 32'h1000;
            r     = $urandom % 8;
            if (r == 0) shares = 32'hFFFFFF00 + 32'($urandom_range(0, 255));
            else if (r == 1) shares = 32'd0;
            else shares = 32'($urandom_range(1, 32'h800));
            doUpd($sformatf("rnd%0d", k), op, side, price, shares);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
